// File: rtl/bsg_chip_pkg.sv
// Shared chip-level definitions for the link reset sequencer: phase
// encoding, default hold length and the per-phase reset decode.
package bsg_chip_pkg;

    // Cycles each link reset phase lasts by default.
    localparam int sdr_reset_hold_cycles_gp = 16;

    typedef enum logic [2:0] {
        SEQ_IDLE       = 3'd0,
        SEQ_ASSERT     = 3'd1,
        SEQ_TOKEN      = 3'd2,
        SEQ_DOWNLINK   = 3'd3,
        SEQ_UPLINK     = 3'd4,
        SEQ_DOWNSTREAM = 3'd5,
        SEQ_DONE       = 3'd6
    } bsg_chip_link_reset_seq_state_e;

    // One bit per link reset; 1 = held in reset.
    typedef struct packed {
        logic token;
        logic downlink;
        logic uplink;
        logic downstream;
        logic noc;
    } link_resets_s;

    localparam link_resets_s all_resets_asserted_lp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Resets are released one at a time, token first, noc last.
    function automatic link_resets_s decode_resets(input bsg_chip_link_reset_seq_state_e s);
        link_resets_s r;
        r = all_resets_asserted_lp;
        case (s)
            SEQ_TOKEN: begin
                r.token = 1'b0;
            end
            SEQ_DOWNLINK: begin
                r.token    = 1'b0;
                r.downlink = 1'b0;
            end
            SEQ_UPLINK: begin
                r.token    = 1'b0;
                r.downlink = 1'b0;
                r.uplink   = 1'b0;
            end
            SEQ_DOWNSTREAM: begin
                r.token      = 1'b0;
                r.downlink   = 1'b0;
                r.uplink     = 1'b0;
                r.downstream = 1'b0;
            end
            SEQ_DONE: begin
                r = '0;
            end
            default: begin
                r = all_resets_asserted_lp;
            end
        endcase
        return r;
    endfunction

    // True in the phases that are timed by the hold counter.
    function automatic logic is_timed_phase(input bsg_chip_link_reset_seq_state_e s);
        return (s == SEQ_ASSERT) || (s == SEQ_TOKEN) || (s == SEQ_DOWNLINK) ||
               (s == SEQ_UPLINK) || (s == SEQ_DOWNSTREAM);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear. When clear and up coincide the
// counter loads the up value, so a cleared counter can start counting
// on the same edge.
module bsg_counter_clear_up #(
    parameter int width_p    = 4,
    parameter int init_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_r;

    // Count register: reset wins, then clear, then increment.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= width_p'(init_val_p);
        end else if (clear_i) begin
            count_r <= width_p'(up_i);
        end else begin
            count_r <= count_r + width_p'(up_i);
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bsg_chip_link_reset_seq.sv
// Sequences the bsg_link_sdr resets out of reset one phase at a time:
// token, downlink, uplink, downstream, then noc. Every output is a flop
// loaded with the decode of the next state, so outputs always match the
// current state without lag or glitches. Outputs are in the core clock
// domain; consumers in other domains synchronize them.
//
// start_i is a one-cycle request sampled on the rising edge; there is no
// ready, and a request in any state other than IDLE restarts the
// sequence from ASSERT.
module bsg_chip_link_reset_seq
    import bsg_chip_pkg::*;
#(
    parameter int hold_cycles_p     = sdr_reset_hold_cycles_gp,
    parameter int seq_count_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    output logic                           token_reset_o,
    output logic                           downlink_reset_o,
    output logic                           uplink_reset_o,
    output logic                           downstream_reset_o,
    output logic                           noc_reset_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [seq_count_width_p-1:0]   seq_count_o,
    output bsg_chip_link_reset_seq_state_e state_o
);

    localparam int cnt_width_lp = $clog2(hold_cycles_p + 1);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(hold_cycles_p - 1);

    bsg_chip_link_reset_seq_state_e state_r, state_n;
    logic [cnt_width_lp-1:0]        hold_cnt;
    logic                           phase_end;
    logic                           restart;
    logic                           cnt_clear;
    logic                           cnt_up;

    link_resets_s                   resets_r;
    logic                           busy_r;
    logic                           done_r;
    logic [seq_count_width_p-1:0]   seq_count_r;

    assign phase_end = (hold_cnt == last_cnt_lp);
    assign restart   = start_i && (state_r != SEQ_IDLE);

    // Counter restarts on every phase change and on a restart request,
    // and only runs inside timed phases, so it never wraps within a phase.
    assign cnt_clear = (state_n != state_r) || restart;
    assign cnt_up    = !cnt_clear && is_timed_phase(state_r);

    bsg_counter_clear_up #(
        .width_p    (cnt_width_lp),
        .init_val_p (0)
    ) hold_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .up_i    (cnt_up),
        .count_o (hold_cnt)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic: start always goes to ASSERT, timed phases advance
    // after their last counted cycle.
    always_comb begin
        state_n = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (start_i) state_n = SEQ_ASSERT;
            end
            SEQ_ASSERT: begin
                if (start_i)        state_n = SEQ_ASSERT;
                else if (phase_end) state_n = SEQ_TOKEN;
            end
            SEQ_TOKEN: begin
                if (start_i)        state_n = SEQ_ASSERT;
                else if (phase_end) state_n = SEQ_DOWNLINK;
            end
            SEQ_DOWNLINK: begin
                if (start_i)        state_n = SEQ_ASSERT;
                else if (phase_end) state_n = SEQ_UPLINK;
            end
            SEQ_UPLINK: begin
                if (start_i)        state_n = SEQ_ASSERT;
                else if (phase_end) state_n = SEQ_DOWNSTREAM;
            end
            SEQ_DOWNSTREAM: begin
                if (start_i)        state_n = SEQ_ASSERT;
                else if (phase_end) state_n = SEQ_DONE;
            end
            SEQ_DONE: begin
                if (start_i) state_n = SEQ_ASSERT;
            end
            default: begin
                state_n = SEQ_IDLE;
            end
        endcase
    end

    // Output flops load the decode of the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resets_r <= all_resets_asserted_lp;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            resets_r <= decode_resets(state_n);
            busy_r   <= is_timed_phase(state_n);
            done_r   <= (state_n == SEQ_DONE);
        end
    end

    // Completed-sequence counter; a restart never reaches DONE through
    // this transition, so it leaves the count alone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seq_count_r <= '0;
        end else if ((state_r == SEQ_DOWNSTREAM) && (state_n == SEQ_DONE)) begin
            seq_count_r <= seq_count_r + 1'b1;
        end
    end

    assign token_reset_o      = resets_r.token;
    assign downlink_reset_o   = resets_r.downlink;
    assign uplink_reset_o     = resets_r.uplink;
    assign downstream_reset_o = resets_r.downstream;
    assign noc_reset_o        = resets_r.noc;
    assign busy_o             = busy_r;
    assign done_o             = done_r;
    assign seq_count_o        = seq_count_r;
    assign state_o            = state_r;

endmodule

// File: tb/tb_bsg_chip_link_reset_seq.sv
// Bench for the link reset sequencer. Two instances run side by side:
// dut_a with hold 4 / count width 8, dut_b with hold 1 / count width 2.
// A timing model (sequence age divided by hold length) predicts the
// outputs after each edge; directed scenarios check latencies and counts.
module tb_bsg_chip_link_reset_seq;
    import bsg_chip_pkg::*;

    localparam int hold_a = 4;
    localparam int width_a = 8;
    localparam int hold_b = 1;
    localparam int width_b = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b1, start_a = 1'b0;
    logic reset_b = 1'b1, start_b = 1'b0;

    logic token_a, downlink_a, uplink_a, downstream_a, noc_a, busy_a, done_a;
    logic [width_a-1:0] seq_a;
    bsg_chip_link_reset_seq_state_e state_a;

    logic token_b, downlink_b, uplink_b, downstream_b, noc_b, busy_b, done_b;
    logic [width_b-1:0] seq_b;
    bsg_chip_link_reset_seq_state_e state_b;

    bsg_chip_link_reset_seq #(.hold_cycles_p(hold_a), .seq_count_width_p(width_a)) dut_a (
        .clk_i(clk), .reset_i(reset_a), .start_i(start_a),
        .token_reset_o(token_a), .downlink_reset_o(downlink_a), .uplink_reset_o(uplink_a),
        .downstream_reset_o(downstream_a), .noc_reset_o(noc_a),
        .busy_o(busy_a), .done_o(done_a), .seq_count_o(seq_a), .state_o(state_a)
    );

    bsg_chip_link_reset_seq #(.hold_cycles_p(hold_b), .seq_count_width_p(width_b)) dut_b (
        .clk_i(clk), .reset_i(reset_b), .start_i(start_b),
        .token_reset_o(token_b), .downlink_reset_o(downlink_b), .uplink_reset_o(uplink_b),
        .downstream_reset_o(downstream_b), .noc_reset_o(noc_b),
        .busy_o(busy_b), .done_o(done_b), .seq_count_o(seq_b), .state_o(state_b)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    // mode: 0 idle, 1 running (age = cycles since entering ASSERT), 2 done.
    int mode_a = 0, age_a = 0, cnt_a = 0;
    int mode_b = 0, age_b = 0, cnt_b = 0;

    task automatic model_step(input logic rst, input logic st, input int hold, input int width,
                              inout int mode, inout int age, inout int cnt);
        if (rst) begin
            mode = 0; age = 0; cnt = 0;
        end else if (st) begin
            mode = 1; age = 0;
        end else if (mode == 1) begin
            age++;
            if (age == 5 * hold) begin
                mode = 2;
                cnt = (cnt + 1) % (1 << width);
            end
        end
    endtask

    // {token, downlink, uplink, downstream, noc, busy, done, count[8:0]}
    function automatic logic [15:0] exp_vec(input int mode, input int age, input int cnt, input int hold);
        logic [4:0] r;
        logic b, d;
        int p;
        r = 5'b11111; b = 1'b0; d = 1'b0;
        if (mode == 1) begin
            p = age / hold;
            b = 1'b1;
            r[4] = (p >= 1) ? 1'b0 : 1'b1;
            r[3] = (p >= 2) ? 1'b0 : 1'b1;
            r[2] = (p >= 3) ? 1'b0 : 1'b1;
            r[1] = (p >= 4) ? 1'b0 : 1'b1;
            r[0] = 1'b1;
        end else if (mode == 2) begin
            r = 5'b00000;
            d = 1'b1;
        end
        return {r, b, d, 9'(cnt)};
    endfunction

    logic [15:0] obs_a, obs_b;
    assign obs_a = {token_a, downlink_a, uplink_a, downstream_a, noc_a, busy_a, done_a, 9'(seq_a)};
    assign obs_b = {token_b, downlink_b, uplink_b, downstream_b, noc_b, busy_b, done_b, 9'(seq_b)};

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    // Drive one cycle on both DUTs, push predictions, then compare after the edge.
    task automatic step(input logic ra, input logic sa, input logic rb, input logic sb);
        logic [15:0] ea, eb;
        @(negedge clk);
        reset_a = ra; start_a = sa; reset_b = rb; start_b = sb;
        model_step(ra, sa, hold_a, width_a, mode_a, age_a, cnt_a);
        model_step(rb, sb, hold_b, width_b, mode_b, age_b, cnt_b);
        exp_q_a.push_back(exp_vec(mode_a, age_a, cnt_a, hold_a));
        exp_q_b.push_back(exp_vec(mode_b, age_b, cnt_b, hold_b));
        @(posedge clk);
        #1;
        ea = exp_q_a.pop_front();
        eb = exp_q_b.pop_front();
        check_eq("sb_a", obs_a, ea);
        check_eq("sb_b", obs_b, eb);
    endtask

    // Idle cycles until done on the chosen DUT; returns edges taken, or -1.
    task automatic wait_done(input bit on_a, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if ((on_a ? done_a : done_b) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int exp_seq_b[5];
        exp_seq_b = '{1, 2, 3, 0, 1};

        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);   // reset beats start
        check_eq("reset_busy_done_a", {14'd0, busy_a, done_a}, 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_hold_a", 16'(state_a), 16'(SEQ_IDLE));

        // Full sequence, hold 4: done at cycle 21, count 1.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("assert_cycle1_a", 16'(state_a), 16'(SEQ_ASSERT));
        wait_done(1'b1, n);
        check_eq("done_latency_a", 16'(n + 1), 16'd21);
        check_eq("seq_count_1_a", 16'(seq_a), 16'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("done_holds_a", 16'(done_a), 16'd1);

        // Restart from DONE: resets reassert, count unchanged, then 2.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("restart_resets_a", {11'd0, token_a, downlink_a, uplink_a, downstream_a, noc_a}, 16'h1f);
        check_eq("restart_busy_a", 16'(busy_a), 16'd1);
        check_eq("restart_count_a", 16'(seq_a), 16'd1);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("seq_count_2_a", 16'(seq_a), 16'd2);

        // Restart mid-DOWNLINK at cycle 10: done at cycle 31.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("in_downlink_a", 16'(state_a), 16'(SEQ_DOWNLINK));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        wait_done(1'b1, n);
        check_eq("restart_done_latency_a", 16'(n + 11), 16'd31);

        // Reset with start at cycle 15 aborts to IDLE.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (14) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("abort_state_a", 16'(state_a), 16'(SEQ_IDLE));
        check_eq("abort_busy_done_a", {14'd0, busy_a, done_a}, 16'd0);
        check_eq("abort_count_a", 16'(seq_a), 16'd0);

        // hold 1, width 2: five back-to-back sequences of 6 cycles each.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            wait_done(1'b0, n);
            check_eq("b2b_latency_b", 16'(n + 1), 16'd6);
            check_eq("b2b_count_b", 16'(seq_b), 16'(exp_seq_b[k]));
        end

        // Two consecutive start pulses: done 6 cycles after the second.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("double_start_state_b", 16'(state_b), 16'(SEQ_ASSERT));
        wait_done(1'b0, n);
        check_eq("double_start_latency_b", 16'(n + 1), 16'd6);

        // Random traffic on both instances, checked by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 25) == 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 8) == 0);
        end

        check_eq("queue_empty", 16'(exp_q_a.size() + exp_q_b.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard timeout in case the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
